// File: rtl/inst_ram_port_arb.sv
// inst_ram_port_arb
//   Shares the single data-side port of the instruction RAM between the CPU
//   memory stage (m0) and the boot loader / debug master (m1), and owns the
//   fetch-port enable and the CPU stall.
//
//   Ports:
//     clk, rst                 clock; asynchronous active-high reset
//     m0_* / m1_*              master request (req/we/addr/wdata), 1-cycle gnt
//                              and ack pulses, read data valid with ack
//     boot_done                loader pulse: image written, switch to RUN
//     ram_ce/we/addr/wdata     registered RAM data-port controls
//     ram_rdata                RAM data_o (1-cycle registered read)
//     rom_ce                   RAM fetch-port enable (high in RUN)
//     cpu_stall                freeze CPU pipeline
//     mode                     0 = BOOT, 1 = RUN
//
//   Access timing: gnt in cycle N (IDLE or RESP), RAM access in N+1 (ISSUE),
//   ack in N+2 (RESP). A new grant may be issued in the RESP cycle.
module inst_ram_port_arb #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              boot_done,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rom_ce,
    output logic              cpu_stall,
    output logic              mode
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state;
    logic              rr_ptr;      // 0: m0 preferred on contention, 1: m1
    logic              srv_m1;      // master being served
    logic              srv_we;      // served access is a write
    logic              boot_pend;   // boot_done seen, waiting for a quiet edge
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              can_grant;
    logic              any_gnt;

    // Grants are combinational in IDLE/RESP. In BOOT only m1 is grantable.
    // Reset also masks grants so nothing is accepted while it is asserted.
    always_comb begin
        can_grant = ~rst & ((state == IDLE) | (state == RESP));
        m0_gnt    = can_grant & mode & m0_req & (~m1_req | ~rr_ptr);
        m1_gnt    = can_grant & m1_req & (~mode | ~m0_req | rr_ptr);
        any_gnt   = m0_gnt | m1_gnt;
    end

    assign rom_ce = mode;

    // Stall from request until ack; the ack cycle itself releases the CPU
    // even if m0 immediately requests again.
    assign cpu_stall = ~mode
                     | (m0_req & ~m0_ack)
                     | ((state == ISSUE) & ~srv_m1);

    // Read data passes straight through in the ack cycle (RAM output is
    // already registered) and is held afterwards; writes leave it unchanged.
    assign m0_rdata = (m0_ack & ~srv_we) ? ram_rdata : m0_rdata_q;
    assign m1_rdata = (m1_ack & ~srv_we) ? ram_rdata : m1_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            srv_m1     <= 1'b0;
            srv_we     <= 1'b0;
            boot_pend  <= 1'b0;
            mode       <= ~BOOT_ON_RESET;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            ram_ce <= 1'b0;
            ram_we <= 1'b0;

            if (m0_ack & ~srv_we) m0_rdata_q <= ram_rdata;
            if (m1_ack & ~srv_we) m1_rdata_q <= ram_rdata;

            if (~mode & boot_done) boot_pend <= 1'b1;

            unique case (state)
                IDLE, RESP: begin
                    if (any_gnt) begin
                        srv_m1    <= m1_gnt;
                        srv_we    <= m1_gnt ? m1_we    : m0_we;
                        ram_ce    <= 1'b1;
                        ram_we    <= m1_gnt ? m1_we    : m0_we;
                        ram_addr  <= m1_gnt ? m1_addr  : m0_addr;
                        ram_wdata <= m1_gnt ? m1_wdata : m0_wdata;
                        // Pointer toggles on every grant, contended or not.
                        rr_ptr    <= ~rr_ptr;
                        state     <= ISSUE;
                    end else begin
                        state <= IDLE;
                        // Mode switch only on a quiet edge; the same-cycle
                        // boot_done is honoured too, so IDLE switches at once.
                        if (~mode & (boot_pend | boot_done)) begin
                            mode      <= 1'b1;
                            boot_pend <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    m0_ack <= ~srv_m1;
                    m1_ack <= srv_m1;
                    state  <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_ram_port_arb.sv
// Directed bench for inst_ram_port_arb with a small registered-read RAM model.
module tb_inst_ram_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        boot_done;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        rom_ce, cpu_stall, mode;
    logic        preload;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    inst_ram_port_arb #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .BOOT_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .boot_done (boot_done),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rom_ce    (rom_ce),
        .cpu_stall (cpu_stall),
        .mode      (mode)
    );

    // RAM data port: synchronous, old-data read, word indexed.
    always @(posedge clk) begin
        if (preload) begin
            mem[0]    <= 32'h0;
            mem[1]    <= 32'hAAAA0004;
            mem[2]    <= 32'hBBBB0008;
            mem[4]    <= 32'h0;
            ram_rdata <= 32'h0;
        end else if (ram_ce) begin
            if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[7:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at the
    // falling edge of the same cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1; boot_done = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (3) next_cycle();
        preload = 1'b0;
        mid();
        check("rst_mode",   {31'b0, mode},      32'd0);
        check("rst_rom_ce", {31'b0, rom_ce},    32'd0);
        check("rst_ram_ce", {31'b0, ram_ce},    32'd0);
        check("rst_addr",   ram_addr,           32'd0);
        check("rst_acks",   {30'b0, m0_ack, m1_ack}, 32'd0);
        next_cycle();
        rst = 1'b0;
        mid();
        check("boot_stall", {31'b0, cpu_stall}, 32'd1);

        // Test 1: m1 boot write; m0 requests concurrently and is ignored.
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0; m1_wdata = 32'h24020005;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        mid();
        check("t1_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        check("t1_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        next_cycle();
        m1_req = 1'b0;
        mid();
        check("t1_ram_ctl", {30'b0, ram_ce, ram_we}, 32'd3);
        check("t1_ram_addr",  ram_addr,  32'h0);
        check("t1_ram_wdata", ram_wdata, 32'h24020005);
        check("t1_no_ack",    {31'b0, m1_ack}, 32'd0);
        next_cycle();
        mid();
        check("t1_m1_ack",    {31'b0, m1_ack}, 32'd1);
        check("t1_resp_m0gnt",{31'b0, m0_gnt}, 32'd0);
        check("t1_resp_ce",   {31'b0, ram_ce}, 32'd0);
        next_cycle();
        m0_req = 1'b0;
        mid();
        check("t1_ack_pulse", {31'b0, m1_ack}, 32'd0);

        // Test 2: boot_done in IDLE, then m0 reads back the boot word.
        next_cycle();
        boot_done = 1'b1;
        mid();
        check("t2_mode_pre", {31'b0, mode}, 32'd0);
        next_cycle();
        boot_done = 1'b0;
        mid();
        check("t2_run", {29'b0, mode, rom_ce, cpu_stall}, 32'b110);
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
        mid();
        check("t2_m0_gnt", {30'b0, m0_gnt, cpu_stall}, 32'b11);
        next_cycle();
        m0_req = 1'b0;
        mid();
        check("t2_issue", {29'b0, cpu_stall, ram_ce, ram_we}, 32'b110);
        next_cycle();
        mid();
        check("t2_ack",   {30'b0, m0_ack, cpu_stall}, 32'b10);
        check("t2_rdata", m0_rdata, 32'h24020005);

        // Test 3: contended continuous reads, grants alternate m0,m1,m0.
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
        mid();
        check("t3_gnt0", {30'b0, m0_gnt, m1_gnt}, 32'b10);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 2) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            mid();
            check("t3_issue_nognt", {30'b0, m0_gnt, m1_gnt}, 32'b00);
            next_cycle();
            mid();
            if (i == 1) begin
                check("t3_m1_ack",   {30'b0, m0_ack, m1_ack}, 32'b01);
                check("t3_m1_rdata", m1_rdata, 32'hBBBB0008);
                check("t3_gnt_m0",   {30'b0, m0_gnt, m1_gnt}, 32'b10);
            end else begin
                check("t3_m0_ack",   {30'b0, m0_ack, m1_ack}, 32'b10);
                check("t3_m0_rdata", m0_rdata, 32'hAAAA0004);
                if (i == 0) check("t3_gnt_m1", {30'b0, m0_gnt, m1_gnt}, 32'b01);
            end
        end

        // Test 4: back-to-back m0 write then read of 0x10.
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h1234;
        mid();
        check("t4_gnt_w", {30'b0, m0_gnt, cpu_stall}, 32'b11);
        next_cycle();
        m0_we = 1'b0;
        mid();
        check("t4_issue_w", {29'b0, cpu_stall, ram_we, m0_gnt}, 32'b110);
        check("t4_wdata",   ram_wdata, 32'h1234);
        next_cycle();
        mid();
        check("t4_ack_w", {29'b0, m0_ack, cpu_stall, m0_gnt}, 32'b101);
        check("t4_rdata_hold", m0_rdata, 32'hAAAA0004);
        next_cycle();
        m0_req = 1'b0;
        mid();
        check("t4_issue_r", {29'b0, cpu_stall, ram_ce, ram_we}, 32'b110);
        check("t4_addr_r",  ram_addr, 32'h10);
        next_cycle();
        mid();
        check("t4_ack_r",   {30'b0, m0_ack, cpu_stall}, 32'b10);
        check("t4_rdata",   m0_rdata, 32'h00001234);

        // Test 5: asynchronous reset during ISSUE of an m1 write.
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hDEAD;
        mid();
        check("t5_gnt", {31'b0, m1_gnt}, 32'd1);
        next_cycle();
        m1_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_ctl", {28'b0, ram_ce, ram_we, m1_ack, mode}, 32'b0000);
        check("t5_async_addr", ram_addr, 32'h0);
        check("t5_boot", {30'b0, rom_ce, cpu_stall}, 32'b01);
        check("t5_rdata_clr", m0_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
        mid();
        check("t5_no_ack", {31'b0, m1_ack}, 32'd0);
        next_cycle();
        mid();
        check("t5_no_ack2", {31'b0, m1_ack}, 32'd0);

        // Test 6: boot_done during ISSUE; ack first, then RUN.
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0;
        mid();
        check("t6_idle_gnt", {31'b0, m1_gnt}, 32'd1);
        next_cycle();
        m1_req = 1'b0; boot_done = 1'b1;
        mid();
        check("t6_mode_issue", {31'b0, mode}, 32'd0);
        next_cycle();
        boot_done = 1'b0;
        mid();
        check("t6_ack",      {30'b0, m1_ack, mode}, 32'b10);
        check("t6_rdata",    m1_rdata, 32'h24020005);
        next_cycle();
        mid();
        check("t6_run", {30'b0, mode, rom_ce}, 32'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_ram_port_arb.md
Name: inst_ram_port_arb

Overview:
- Sequences and shares the single data-side port (ce/we/addr/data_i/data_o) of the instruction RAM between two masters.
- Masters: m0 = CPU memory stage (lw/sw into instruction space); m1 = boot loader / debug.
- Owns the fetch-port enable (rom_ce) and the CPU stall.
- Sits between the MEM stage, the loader and inst_ram.

Parameters:
ADDR_W, 32, address width of both masters and RAM port
DATA_W, 32, data width
BOOT_ON_RESET, 1, 1 = leave reset in BOOT mode; 0 = leave reset in RUN mode

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
m0_req  in  1  CPU access request, held until m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  byte address
m0_wdata  in  DATA_W  write data
m0_gnt  out  1  request accepted (1-cycle pulse)
m0_ack  out  1  access complete (1-cycle pulse)
m0_rdata  out  DATA_W  read data, valid with m0_ack on reads
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata  same as m0_*, for loader/debug
boot_done  in  1  loader pulse: image written, switch to RUN
ram_ce  out  1  RAM data-port chip enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM data_i
ram_rdata  in  DATA_W  RAM data_o (registered in RAM, 1-cycle read latency)
rom_ce  out  1  RAM fetch-port enable
cpu_stall  out  1  freeze CPU pipeline
mode  out  1  0 = BOOT, 1 = RUN

Behaviour:
- Reset (async, rst=1):
  - State IDLE; all gnt/ack = 0; ram_ce/ram_we = 0; ram_addr/ram_wdata = 0; rdata = 0.
  - rr pointer = m0 first.
  - mode = ~BOOT_ON_RESET.
  - An in-flight access is dropped; no ack is issued.
- Mode:
  - BOOT: rom_ce = 0, cpu_stall = 1, only m1 grantable; m0_req is ignored, no gnt.
  - RUN: rom_ce = 1.
  - boot_done is latched as pending; the switch to RUN occurs on the first edge where the FSM is IDLE or RESP with no new grant.
  - boot_done in RUN is ignored.
- FSM states: IDLE, ISSUE, RESP.
  - A grant is allowed in IDLE or RESP (combinational gnt, same cycle as req).
  - Capture edge: the granted master's we/addr/wdata are registered onto ram_*; ram_ce = 1; next state ISSUE.
  - ISSUE (1 cycle): RAM samples at the end of the cycle; next state RESP.
  - RESP: ack of the served master = 1; rdata = ram_rdata (reads); for writes rdata holds its previous value. A new grant -> ISSUE, otherwise -> IDLE; ram_ce/ram_we = 0 unless a new grant.
- Timing:
  - Latency: gnt in cycle N, RAM access in N+1, ack in N+2.
  - Back-to-back throughput: one access per 2 cycles.
- Arbitration:
  - Single requester is granted.
  - Both requesting: round-robin; the pointer flips to the other master after every grant.
  - In BOOT, m1 always wins.
- Masters must keep req, we, addr and wdata stable until gnt; req may drop after gnt.
- Address: ram_addr is the full byte address; the RAM word-indexes internally. No alignment check.
- cpu_stall in RUN = m0_req & ~m0_ack, or m0 granted and not yet acked. It is high from req through the gnt cycle and the ISSUE cycle, and low in the ack cycle.
- Fetch/data same-address in the same cycle: the RAM's old-data semantics apply; no extra interlock.

Test Plan:
1. BOOT_ON_RESET=1, release rst: mode=0, rom_ce=0, cpu_stall=1. m1 writes 0x24020005 to 0x0 -> m1_gnt at N, ram_ce=1/ram_we=1/ram_addr=0x0 at N+1, m1_ack at N+2. m0_req in BOOT -> no m0_gnt.
2. After test 1, pulse boot_done in IDLE -> mode=1, rom_ce=1 next edge, cpu_stall=0. m0 reads 0x0 -> m0_ack at N+2 with m0_rdata=0x24020005.
3. RUN, m0 and m1 request continuously (reads of 0x4/0x8): grants alternate m0,m1,m0 every 2 cycles, starting with m0; each ack is 2 cycles after its gnt with the correct data.
4. Back-to-back m0 write 0x1234 to 0x10, then read 0x10: second gnt in the RESP cycle of the first; read ack returns 0x00001234; cpu_stall is high except in ack cycles.
5. Assert rst during ISSUE of an m1 write: all outputs 0 immediately (asynchronous); no m1_ack; FSM IDLE after release; mode re-enters BOOT.
6. boot_done pulse during an ISSUE cycle: current access acks normally, then mode=1 on the following edge.
